// File: rtl/uart_tx_fifo_gen.sv
// uart_tx_fifo_gen: parametrised UART transmitter with an integrated transmit FIFO.
// Upstream pushes words with txLoadIN while txReadyOUT is high. The serialiser
// pops words and sends frames (start, data LSB first, optional parity, stop)
// back to back with no idle gap between them.
module uart_tx_fifo_gen #(
  parameter int         CLOCK_FREQUENCY = 50_000_000,
  parameter int         BAUD_RATE       = 115200,
  parameter int         DATA_BITS       = 8,
  parameter logic [1:0] PARITY          = 2'b01,
  parameter int         STOP_BITS       = 1,
  parameter int         FIFO_DEPTH      = 16
) (
  input  logic                          clockIN,
  input  logic                          nTxResetIN,
  input  logic [DATA_BITS-1:0]          txDataIN,
  input  logic                          txLoadIN,
  input  logic                          txErrClrIN,
  output logic                          txReadyOUT,
  output logic                          txIdleOUT,
  output logic [$clog2(FIFO_DEPTH):0]   txLevelOUT,
  output logic                          txOverflowOUT,
  output logic                          txOUT
);

  localparam int BAUD_DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int ADDR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LEVEL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [CNT_W-1:0]   BAUD_LOAD  = CNT_W'(BAUD_DIV - 1);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);
  localparam logic [3:0]         LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0]         LAST_STOP  = 4'(STOP_BITS - 1);
  localparam logic               PAR_EN     = (PARITY == 2'b01) || (PARITY == 2'b10);
  localparam logic               PAR_ODD    = (PARITY == 2'b01);

  // Illegal configurations stop elaboration instead of being clamped.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
    $error("uart_tx_fifo_gen: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStopBits
    $error("uart_tx_fifo_gen: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("uart_tx_fifo_gen: FIFO_DEPTH must be a power of two >= 2");
  end
  if (BAUD_DIV < 2) begin : gBadBaudDiv
    $error("uart_tx_fifo_gen: CLOCK_FREQUENCY / BAUD_RATE must be >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} txState_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] fifoMem [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wrPtr;
  logic [ADDR_W-1:0]    rdPtr;
  logic [LEVEL_W-1:0]   level;
  logic                 overflow;
  logic                 fifoEmpty;
  logic                 fifoFull;
  logic                 pushFifo;
  logic                 popFifo;
  logic [DATA_BITS-1:0] fifoHead;

  // Serialiser state
  txState_t             state;
  txState_t             stateNext;
  logic [DATA_BITS-1:0] shiftReg;
  logic [DATA_BITS-1:0] shiftNext;
  logic [3:0]           bitCnt;
  logic [3:0]           bitCntNext;
  logic [CNT_W-1:0]     baudCnt;
  logic [CNT_W-1:0]     baudCntNext;
  logic                 parityAcc;
  logic                 parityNext;
  logic                 txReg;
  logic                 txNext;
  logic                 bitEnd;

  assign fifoEmpty = (level == '0);
  assign fifoFull  = (level == FULL_LEVEL);
  assign pushFifo  = txLoadIN && !fifoFull;
  assign fifoHead  = fifoMem[rdPtr];
  assign bitEnd    = (baudCnt == '0);

  assign txReadyOUT    = !fifoFull;
  assign txIdleOUT     = (state == IDLE) && fifoEmpty;
  assign txLevelOUT    = level;
  assign txOverflowOUT = overflow;
  assign txOUT         = txReg;

  // FIFO storage write port
  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are valid, so clearing the data would only cost a wide reset net.
  always_ff @(posedge clockIN) begin
    if (pushFifo) begin
      fifoMem[wrPtr] <= txDataIN;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update from the same pre-edge values and simulation matches the hardware.
  always_ff @(posedge clockIN or negedge nTxResetIN) begin
    if (!nTxResetIN) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pushFifo) begin
        wrPtr <= wrPtr + ADDR_W'(1);
      end
      if (popFifo) begin
        rdPtr <= rdPtr + ADDR_W'(1);
      end
      case ({pushFifo, popFifo})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
      // A dropped write outranks a clear in the same cycle.
      if (txLoadIN && fifoFull) begin
        overflow <= 1'b1;
      end else if (txErrClrIN) begin
        overflow <= 1'b0;
      end
    end
  end

  // Serialiser state register and datapath registers
  always_ff @(posedge clockIN or negedge nTxResetIN) begin
    if (!nTxResetIN) begin
      state     <= IDLE;
      shiftReg  <= '0;
      bitCnt    <= '0;
      baudCnt   <= '0;
      parityAcc <= 1'b0;
      txReg     <= 1'b1;
    end else begin
      state     <= stateNext;
      shiftReg  <= shiftNext;
      bitCnt    <= bitCntNext;
      baudCnt   <= baudCntNext;
      parityAcc <= parityNext;
      txReg     <= txNext;
    end
  end

  // Next-state and datapath update: bit sequencing and baud counting
  // NOTE: every signal assigned here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    stateNext   = state;
    shiftNext   = shiftReg;
    bitCntNext  = bitCnt;
    baudCntNext = baudCnt;
    parityNext  = parityAcc;
    case (state)
      IDLE: begin
        if (popFifo) begin
          stateNext   = START;
          shiftNext   = fifoHead;
          baudCntNext = BAUD_LOAD;
          parityNext  = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext   = DATA;
          bitCntNext  = '0;
          baudCntNext = BAUD_LOAD;
          shiftNext   = shiftReg >> 1;
          parityNext  = parityAcc ^ shiftReg[0];
        end else begin
          baudCntNext = baudCnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (bitEnd) begin
          baudCntNext = BAUD_LOAD;
          if (bitCnt == LAST_DATA) begin
            stateNext  = PAR_EN ? PAR : STOP;
            bitCntNext = '0;
          end else begin
            bitCntNext = bitCnt + 4'd1;
            shiftNext  = shiftReg >> 1;
            parityNext = parityAcc ^ shiftReg[0];
          end
        end else begin
          baudCntNext = baudCnt - CNT_W'(1);
        end
      end
      PAR: begin
        if (bitEnd) begin
          stateNext   = STOP;
          bitCntNext  = '0;
          baudCntNext = BAUD_LOAD;
        end else begin
          baudCntNext = baudCnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (bitEnd) begin
          baudCntNext = BAUD_LOAD;
          if (bitCnt == LAST_STOP) begin
            bitCntNext = '0;
            if (popFifo) begin
              stateNext  = START;
              shiftNext  = fifoHead;
              parityNext = 1'b0;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            bitCntNext = bitCnt + 4'd1;
          end
        end else begin
          baudCntNext = baudCnt - CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Outputs: FIFO pop strobe and the next registered line level
  always_comb begin
    popFifo = 1'b0;
    txNext  = txReg;
    if (state == IDLE) begin
      popFifo = !fifoEmpty;
    end else if (state == STOP && bitEnd && bitCnt == LAST_STOP) begin
      popFifo = !fifoEmpty;
    end

    if (state == IDLE) begin
      txNext = fifoEmpty;
    end else if (bitEnd) begin
      case (stateNext)
        START:   txNext = 1'b0;
        DATA:    txNext = shiftReg[0];
        PAR:     txNext = PAR_ODD ? ~parityAcc : parityAcc;
        default: txNext = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_gen.sv
// tb_uart_tx_fifo_gen: directed self-checking bench for uart_tx_fifo_gen.
// Four instances cover the default, shallow-FIFO, 7E2 and 9N1 configurations
// at BAUD_DIV = 10. Expected line levels are written out by hand per frame.
module tb_uart_tx_fifo_gen;

  localparam int BAUD_DIV = 10;

  logic clockIN;
  logic nTxResetIN;

  // Instance A: defaults (8 data, odd parity, 1 stop, depth 16)
  logic [7:0] dataA;
  logic       loadA, clrA, readyA, idleA, ovfA, txA;
  logic [4:0] levelA;
  // Instance B: depth 4
  logic [7:0] dataB;
  logic       loadB, clrB, readyB, idleB, ovfB, txB;
  logic [2:0] levelB;
  // Instance C: 7 data, even parity, 2 stop
  logic [6:0] dataC;
  logic       loadC, clrC, readyC, idleC, ovfC, txC;
  logic [4:0] levelC;
  // Instance D: 9 data, no parity, 1 stop
  logic [8:0] dataD;
  logic       loadD, clrD, readyD, idleD, ovfD, txD;
  logic [4:0] levelD;

  int compared   = 0;
  int mismatched = 0;

  uart_tx_fifo_gen #(
    .CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000)
  ) dutA (
    .clockIN(clockIN), .nTxResetIN(nTxResetIN), .txDataIN(dataA), .txLoadIN(loadA),
    .txErrClrIN(clrA), .txReadyOUT(readyA), .txIdleOUT(idleA), .txLevelOUT(levelA),
    .txOverflowOUT(ovfA), .txOUT(txA)
  );

  uart_tx_fifo_gen #(
    .CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(4)
  ) dutB (
    .clockIN(clockIN), .nTxResetIN(nTxResetIN), .txDataIN(dataB), .txLoadIN(loadB),
    .txErrClrIN(clrB), .txReadyOUT(readyB), .txIdleOUT(idleB), .txLevelOUT(levelB),
    .txOverflowOUT(ovfB), .txOUT(txB)
  );

  uart_tx_fifo_gen #(
    .CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
    .PARITY(2'b10), .STOP_BITS(2)
  ) dutC (
    .clockIN(clockIN), .nTxResetIN(nTxResetIN), .txDataIN(dataC), .txLoadIN(loadC),
    .txErrClrIN(clrC), .txReadyOUT(readyC), .txIdleOUT(idleC), .txLevelOUT(levelC),
    .txOverflowOUT(ovfC), .txOUT(txC)
  );

  uart_tx_fifo_gen #(
    .CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(9),
    .PARITY(2'b00)
  ) dutD (
    .clockIN(clockIN), .nTxResetIN(nTxResetIN), .txDataIN(dataD), .txLoadIN(loadD),
    .txErrClrIN(clrD), .txReadyOUT(readyD), .txIdleOUT(idleD), .txLevelOUT(levelD),
    .txOverflowOUT(ovfD), .txOUT(txD)
  );

  // Free-running 100 MHz-style clock, 10 time units per period
  initial clockIN = 1'b0;
  always #5 clockIN = ~clockIN;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and land 1 unit after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clockIN);
    #1;
  endtask

  function automatic logic lineOf(input int sel);
    case (sel)
      0:       return txA;
      1:       return txB;
      2:       return txC;
      3:       return txD;
      default: return 1'bx;
    endcase
  endfunction

  // Called on the first cycle of a start bit. Checks the first and last cycle
  // of every bit (bits listed LSB = start bit) and returns on the first cycle
  // after the frame.
  task automatic checkFrame(input int sel, input logic [15:0] bits,
                            input int nBits, input string tag);
    for (int b = 0; b < nBits; b++) begin
      check($sformatf("%s bit%0d first", tag, b), 32'(lineOf(sel)), 32'(bits[b]));
      tick(BAUD_DIV - 1);
      check($sformatf("%s bit%0d last", tag, b), 32'(lineOf(sel)), 32'(bits[b]));
      tick(1);
    end
  endtask

  initial begin
    logic sawLow;
    nTxResetIN = 1'b0;
    dataA = '0; loadA = 1'b0; clrA = 1'b0;
    dataB = '0; loadB = 1'b0; clrB = 1'b0;
    dataC = '0; loadC = 1'b0; clrC = 1'b0;
    dataD = '0; loadD = 1'b0; clrD = 1'b0;

    // Reset state
    tick(2);
    check("reset txOUT",      32'(txA),    32'd1);
    check("reset ready",      32'(readyA), 32'd1);
    check("reset idle",       32'(idleA),  32'd1);
    check("reset level",      32'(levelA), 32'd0);
    check("reset overflow",   32'(ovfA),   32'd0);
    nTxResetIN = 1'b1;
    tick(2);

    // 1: single 0xA5 frame, odd parity -> parity bit 1
    dataA = 8'hA5; loadA = 1'b1;
    tick(1);
    loadA = 1'b0;
    check("t1 level after push", 32'(levelA), 32'd1);
    check("t1 idle falls",       32'(idleA),  32'd0);
    check("t1 line still high",  32'(txA),    32'd1);
    tick(1);
    check("t1 level after pop",  32'(levelA), 32'd0);
    checkFrame(0, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, "t1 A5");
    check("t1 idle after frame", 32'(idleA), 32'd1);
    check("t1 line idle high",   32'(txA),   32'd1);

    // 2: 0x00 then 0xFF back to back, both with parity bit 1
    dataA = 8'h00; loadA = 1'b1;
    tick(1);
    dataA = 8'hFF;
    tick(1);
    loadA = 1'b0;
    check("t2 level push+pop", 32'(levelA), 32'd1);
    checkFrame(0, 16'({1'b1, 1'b1, 8'h00, 1'b0}), 11, "t2 00");
    checkFrame(0, 16'({1'b1, 1'b1, 8'hFF, 1'b0}), 11, "t2 FF");
    check("t2 idle after frames", 32'(idleA),  32'd1);
    check("t2 level empty",       32'(levelA), 32'd0);

    // 3: depth-4 FIFO, six consecutive pushes while idle
    loadB = 1'b1; dataB = 8'h11;
    tick(1);
    check("t3 level w0", 32'(levelB), 32'd1);
    check("t3 ready w0", 32'(readyB), 32'd1);
    dataB = 8'h22;
    tick(1);
    check("t3 level w1 (pop)", 32'(levelB), 32'd1);
    check("t3 start bit",      32'(txB),    32'd0);
    dataB = 8'h33;
    tick(1);
    check("t3 level w2", 32'(levelB), 32'd2);
    dataB = 8'h44;
    tick(1);
    check("t3 level w3", 32'(levelB), 32'd3);
    dataB = 8'h55;
    tick(1);
    check("t3 level full",   32'(levelB), 32'd4);
    check("t3 ready full",   32'(readyB), 32'd0);
    check("t3 no overflow",  32'(ovfB),   32'd0);
    dataB = 8'h66;
    tick(1);
    loadB = 1'b0;
    check("t3 level dropped", 32'(levelB), 32'd4);
    check("t3 overflow set",  32'(ovfB),   32'd1);
    check("t3 ready still 0", 32'(readyB), 32'd0);
    tick(1);
    check("t3 overflow sticky", 32'(ovfB), 32'd1);
    clrB = 1'b1;
    tick(1);
    clrB = 1'b0;
    check("t3 overflow cleared", 32'(ovfB), 32'd0);

    // 4: 7 data bits, even parity, 2 stop bits, 0x41 -> parity 0
    dataC = 7'h41; loadC = 1'b1;
    tick(1);
    loadC = 1'b0;
    tick(1);
    checkFrame(2, 16'({1'b1, 1'b1, 1'b0, 7'h41, 1'b0}), 11, "t4 41");
    check("t4 idle after frame", 32'(idleC), 32'd1);

    // 5: 9 data bits, no parity, 0x1FF
    dataD = 9'h1FF; loadD = 1'b1;
    tick(1);
    loadD = 1'b0;
    tick(1);
    checkFrame(3, 16'({1'b1, 9'h1FF, 1'b0}), 11, "t5 1FF");
    check("t5 idle after frame", 32'(idleD), 32'd1);

    // 6: asynchronous reset during data bit 3 with two words queued
    dataA = 8'h00; loadA = 1'b1;
    tick(3);
    loadA = 1'b0;
    check("t6 queued level", 32'(levelA), 32'd2);
    tick(43);
    check("t6 line low in data bit 3", 32'(txA), 32'd0);
    #2;
    nTxResetIN = 1'b0;
    #1;
    check("t6 async txOUT",   32'(txA),    32'd1);
    check("t6 async level",   32'(levelA), 32'd0);
    check("t6 async ready",   32'(readyA), 32'd1);
    check("t6 async idle",    32'(idleA),  32'd1);
    tick(2);
    nTxResetIN = 1'b1;
    sawLow = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (txA !== 1'b1) sawLow = 1'b1;
    end
    check("t6 no frames after reset", 32'(sawLow), 32'd0);
    check("t6 idle after release",    32'(idleA),  32'd1);
    check("t6 ready after release",   32'(readyA), 32'd1);
    check("t6 level after release",   32'(levelA), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
